// File: rtl/lc3b_types.sv
// lc3b_types: shared lc3b datapath types.
//   lc3b_word      - 16-bit machine word / physical address
//   lc3b_line      - 128-bit cache line
//   lc3b_arb_state - memory arbiter FSM state
//   lc3b_arb_sel   - which cache currently owns the memory port
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lc3b_arb_state;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } lc3b_arb_sel;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter used for grant statistics.
//   clk   - clock
//   rst   - synchronous active-high reset (count -> 0)
//   clear - synchronous clear (count -> 0)
//   inc   - add one unless already all-ones
//   count - current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the physical-memory line port between the icache and
// dcache miss paths. One side is granted at a time (round-robin on ties);
// the memory response is routed only to the granted side.
//   clk, rst                       - clock, synchronous active-high reset
//   i_read/i_addr/i_rdata/i_resp   - icache line-fill port
//   d_read/d_write/d_addr/d_wdata/
//   d_rdata/d_resp                 - dcache fill / write-back port
//   pmem_*                         - physical memory port
//   i_grants/d_grants              - saturating per-side grant counts
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants
);

    lc3b_arb_state state_reg;
    lc3b_arb_sel   grant_reg;
    lc3b_arb_sel   last_grant_reg;
    logic          rd_reg;
    logic          wr_reg;

    logic          d_req;
    logic          sel_i;
    logic          sel_d;

    assign d_req = d_read | d_write;
    assign sel_i = (state_reg == BUSY) && (grant_reg == ARB_I);
    assign sel_d = (state_reg == BUSY) && (grant_reg == ARB_D);

    // Strobes are captured at grant time so a requester that drops its
    // request mid-transaction cannot abort the memory cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= ARB_NONE;
            last_grant_reg <= ARB_I;
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // dcache wins if alone, or on a tie when icache went last
                    if (d_req && (!i_read || (last_grant_reg == ARB_I))) begin
                        grant_reg <= ARB_D;
                        rd_reg    <= d_read;
                        wr_reg    <= d_write;
                        state_reg <= BUSY;
                    end else if (i_read) begin
                        grant_reg <= ARB_I;
                        rd_reg    <= 1'b1;
                        wr_reg    <= 1'b0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        last_grant_reg <= grant_reg;
                        grant_reg      <= ARB_NONE;
                        rd_reg         <= 1'b0;
                        wr_reg         <= 1'b0;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    // one dead cycle lets the requester drop its request
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pmem_read  = rd_reg;
    assign pmem_write = wr_reg;

    always_comb begin
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_rdata    = '0;
        d_rdata    = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        if (sel_i) begin
            pmem_addr = i_addr;
            i_rdata   = pmem_rdata;
            i_resp    = pmem_resp;
        end else if (sel_d) begin
            pmem_addr  = d_addr;
            pmem_wdata = d_wdata;
            d_rdata    = pmem_rdata;
            d_resp     = pmem_resp;
        end
    end

    // index 0 = icache, index 1 = dcache
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = sel_i & pmem_resp;
    assign cnt_inc[1] = sel_d & pmem_resp;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clear (1'b0),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign i_grants = cnt_val[0];
    assign d_grants = cnt_val[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// A small memory model answers each strobe after mem_lat cycles with data
// derived from the address; late_resp injects a stray response.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [CNT_W-1:0]  i_grants;
    logic [CNT_W-1:0]  d_grants;

    int   n_vec = 0;
    int   n_err = 0;
    int   mem_lat = 3;
    int   mem_cnt = 0;
    logic late_resp = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .i_grants   (i_grants),
        .d_grants   (d_grants)
    );

    function automatic logic [LINE_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return {8{a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    // memory model: respond in the (mem_lat+1)-th cycle of a held strobe
    logic strobe;
    assign strobe     = pmem_read | pmem_write;
    assign pmem_resp  = (strobe && (mem_cnt == mem_lat)) || late_resp;
    assign pmem_rdata = mem_data(pmem_addr);

    always @(posedge clk) begin
        if (strobe && !pmem_resp) mem_cnt <= mem_cnt + 1;
        else                      mem_cnt <= 0;
    end

    always @(negedge clk) begin
        assert (!(d_read && d_write)) else $error("illegal d_read+d_write");
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit want_d, input int max_cyc, output int used);
        used = 0;
        while (!(want_d ? d_resp : i_resp) && used < max_cyc) begin
            cyc();
            used++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        late_resp = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    int   used;
    int   n_got;
    bit   order [4];
    int   i_off;
    int   d_off;
    logic ir;
    logic dr;

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_i_grants", i_grants, 0);
        chk("rst_d_grants", d_grants, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // ---- icache only, latency 3 ----
        mem_lat = 3;
        i_read  = 1'b1;
        i_addr  = 16'h0040;
        cyc();
        chk("s1_pmem_read", pmem_read, 1);
        chk("s1_pmem_write", pmem_write, 0);
        chk("s1_pmem_addr", pmem_addr, 16'h0040);
        wait_resp(1'b0, 10, used);
        chk("s1_latency", used, 3);
        chk("s1_i_resp", i_resp, 1);
        chk("s1_i_rdata", i_rdata, mem_data(16'h0040));
        chk("s1_d_resp", d_resp, 0);
        cyc();
        i_read = 1'b0;
        chk("s1_done_strobe", pmem_read, 0);
        chk("s1_i_grants", i_grants, 1);
        chk("s1_d_grants", d_grants, 0);

        // ---- simultaneous requests after reset: dcache first ----
        do_reset();
        i_read  = 1'b1;
        i_addr  = 16'h0080;
        d_write = 1'b1;
        d_addr  = 16'h1000;
        d_wdata = {16{8'hA5}};
        cyc();
        chk("s2_pmem_write", pmem_write, 1);
        chk("s2_pmem_read", pmem_read, 0);
        chk("s2_pmem_addr", pmem_addr, 16'h1000);
        chk("s2_pmem_wdata", pmem_wdata, {16{8'hA5}});
        wait_resp(1'b1, 10, used);
        chk("s2_d_latency", used, 3);
        chk("s2_d_resp", d_resp, 1);
        chk("s2_i_resp_quiet", i_resp, 0);
        chk("s2_addr_held", pmem_addr, 16'h1000);
        cyc();
        d_write = 1'b0;
        chk("s2_done_strobe", pmem_read | pmem_write, 0);
        cyc();
        chk("s2_idle_strobe", pmem_read | pmem_write, 0);
        cyc();
        chk("s2_i_pmem_read", pmem_read, 1);
        chk("s2_i_pmem_addr", pmem_addr, 16'h0080);
        chk("s2_i_pmem_wdata", pmem_wdata, 0);
        wait_resp(1'b0, 10, used);
        chk("s2_i_resp", i_resp, 1);
        chk("s2_i_rdata", i_rdata, mem_data(16'h0080));
        cyc();
        i_read = 1'b0;
        chk("s2_i_grants", i_grants, 1);
        chk("s2_d_grants", d_grants, 1);

        // ---- both request continuously: D, I, D, I ----
        do_reset();
        mem_lat = 2;
        i_addr  = 16'h0100;
        d_addr  = 16'h0200;
        i_read  = 1'b1;
        d_read  = 1'b1;
        n_got   = 0;
        i_off   = 0;
        d_off   = 0;
        for (int c = 0; c < 100 && n_got < 4; c++) begin
            cyc();
            ir = i_resp;
            dr = d_resp;
            chk("s3_resp_onehot", ir & dr, 0);
            if (i_off == 1) begin i_read = 1'b0; i_off = 2; end
            else if (i_off == 2) begin i_read = 1'b1; i_off = 0; end
            if (d_off == 1) begin d_read = 1'b0; d_off = 2; end
            else if (d_off == 2) begin d_read = 1'b1; d_off = 0; end
            if (ir && n_got < 4) begin order[n_got] = 1'b0; n_got++; i_off = 1; end
            if (dr && n_got < 4) begin order[n_got] = 1'b1; n_got++; d_off = 1; end
        end
        chk("s3_grant_count", n_got, 4);
        chk("s3_order0_D", order[0], 1);
        chk("s3_order1_I", order[1], 0);
        chk("s3_order2_D", order[2], 1);
        chk("s3_order3_I", order[3], 0);
        cyc();
        i_read = 1'b0;
        d_read = 1'b0;
        chk("s3_i_grants", i_grants, 2);
        chk("s3_d_grants", d_grants, 2);

        // ---- reset during a dcache read in flight ----
        do_reset();
        mem_lat = 5;
        d_read  = 1'b1;
        d_addr  = 16'h2000;
        cyc();
        chk("s4_pmem_read", pmem_read, 1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("s4_rst_strobes", pmem_read | pmem_write, 0);
        chk("s4_rst_d_resp", d_resp, 0);
        rst    = 1'b0;
        d_read = 1'b0;
        cyc();
        late_resp = 1'b1;
        #1;
        chk("s4_late_d_resp", d_resp, 0);
        chk("s4_late_i_resp", i_resp, 0);
        chk("s4_late_d_rdata", d_rdata, 0);
        late_resp = 1'b0;
        cyc();
        chk("s4_idle_strobe", pmem_read, 0);
        chk("s4_d_grants", d_grants, 0);

        // ---- back-to-back icache with a held request; counter saturation ----
        do_reset();
        mem_lat = 1;
        i_addr  = 16'h0300;
        i_read  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("s5_pmem_read", pmem_read, 1);
            wait_resp(1'b0, 10, used);
            chk("s5_latency", used, 1);
            chk("s5_i_resp", i_resp, 1);
            cyc();
            chk("s5_done_gap", pmem_read, 0);
            chk("s5_i_grants", i_grants, (k < 3) ? k : 3);
            cyc();
            chk("s5_idle_gap", pmem_read, 0);
        end
        i_read = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
